serial_adder: RTL
=================

# serial_adder

Parametrised bit-serial adder/subtractor built around a single registered 1-bit full-adder cell. It takes two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first. When finished it presents the sum, carry-out and signed overflow with a one-cycle done pulse. It is the multi-bit, sequential, add/subtract generalisation of the team's 1-bit full adder, for area-constrained datapaths where WIDTH+1 cycles of latency per operation are acceptable.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- sys_clk  in  1  single clock; all state updates on the rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- sub  in  1  0 = add, 1 = subtract; latched with operands.
- a  in  WIDTH  operand A; latched on accepted start.
- b  in  WIDTH  operand B; latched on accepted start.
- cin  in  1  carry-in for add, borrow-in for subtract; latched on accepted start.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; results valid.
- sum  out  WIDTH  result; valid from done until the next accepted start.
- cout  out  1  raw carry-out of the MSB stage (subtract: 1 = no borrow).
- ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- Clock and reset: one clock, sys_clk; reset is asynchronous and active-low, sys_rst_n.
- States:
  - IDLE: start=1 moves to RUN.
  - RUN: stays for exactly WIDTH cycles, then moves to DONE.
  - DONE: unconditionally returns to IDLE after one cycle.
- Accept, on an IDLE edge with start=1:
  - Latch a into shift register A.
  - Latch b, or ~b when sub=1, into shift register B.
  - Carry register := cin when sub=0, ~cin when sub=1.
  - Bit counter := 0.
- Arithmetic:
  - sub=0: sum = (a + b + cin) mod 2^WIDTH.
  - sub=1: sum = (a - b - cin) mod 2^WIDTH.
- RUN, each cycle:
  - s = A[0]^B[0]^c; c_next = majority(A[0], B[0], c).
  - sum <= {s, sum[WIDTH-1:1]}; A and B shift right by one.
  - Carry register := c_next; counter increments.
- Final RUN cycle (counter = WIDTH-1):
  - The carry-in to the MSB (the carry register before update) is captured for ovf.
  - cout := c_next.
- start while busy (RUN or DONE) is ignored and not queued; the operation in flight is unaffected.
- Operand inputs change freely after acceptance without effect.

## Timing
- Reset values (immediate on sys_rst_n low, independent of clock):
  - state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, carry and counter cleared.
- Reset asserted mid-operation aborts it; no done pulse is issued afterwards.
- Latency: start sampled at edge k.
  - busy rises after edge k.
  - Bits are processed at edges k+1..k+WIDTH.
  - done=1 and final sum/cout/ovf are visible after edge k+WIDTH.
  - done falls and busy falls after edge k+WIDTH+1.
  - Earliest next accept is edge k+WIDTH+2.
  - Throughput: one operation per WIDTH+2 cycles.
- While busy, sum shows partial shift contents and carries no meaning. cout and ovf hold their previous values until the final RUN edge.
- Once DONE is reached, sum/cout/ovf hold stable until the next accepted start.
- Bit counter is $clog2(WIDTH) bits wide. It must not wrap before WIDTH-1 is detected, including for WIDTH a power of two.

## Test plan
- WIDTH=8, add 0x3C + 0x0F, cin=0, start at edge k -> done high only after edge k+8; sum=0x4B, cout=0, ovf=0.
- Add 0xFF + 0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Add 0x7F + 0x01 -> sum=0x80, cout=0, ovf=1. Add 0x00 + 0x00, cin=1 -> sum=0x01.
- Subtract 0x05 - 0x07, cin=0 -> sum=0xFE, cout=0, ovf=0. Subtract 0x80 - 0x01 -> sum=0x7F, cout=1, ovf=1. Subtract 0x10 - 0x00, cin=1 -> sum=0x0F, cout=1.
- Start held high continuously with new operands every cycle -> one done per 10 cycles. Each result matches the operands present at its accept edge; start pulses during busy are ignored.
- sys_rst_n pulsed low (mid-cycle, asynchronous) at edge k+4 of an operation -> all outputs 0 immediately. No done follows. A fresh start after reset release gives a correct result.
- Randomised sweep at WIDTH=2, 8, 16, 32 against a reference model -> sum/cout/ovf exact for all sampled a, b, cin, sub. Each done is exactly one cycle wide.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one registered full-adder cell processes one operand bit
// per clock, LSB first, and reports sum, carry-out and signed overflow with a done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // {carry_out, sum_bit} of one full-adder cell.
  function automatic logic [1:0] fa_cell(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [1:0]       w_fa;
  logic             w_s;
  logic             w_c_next;

  assign w_fa     = fa_cell(r_a[0], r_b[0], r_c);
  assign w_s      = w_fa[0];
  assign w_c_next = w_fa[1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + ~cin, so borrow-in inverts into the carry seed.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= cin ^ sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum <= {w_s, r_sum[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            // r_c is still the carry into the MSB here, so ovf is its XOR with carry-out.
            r_cout  <= w_c_next;
            r_ovf   <= r_c ^ w_c_next;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule
